// File: rtl/lcd_msg_sched.sv
// Text LCD message scheduler: arbitrates three message requesters once per frame and
// streams 64 ROM characters per frame to the LCD with a fetch/setup/strobe cycle each.
// Ports: clk/rst_n (sync, active-low); req in, gnt/frame_done out; rom_addr out, rom_data in;
//        lcd_en/lcd_rs/lcd_rw/lcd_db/lcd_rst drive the LCD pins.
module lcd_msg_sched #(
  parameter int DWELL    = 4,
  parameter int INIT_CYC = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] req,
  output logic [2:0] gnt,
  output logic       frame_done,
  output logic [7:0] rom_addr,
  input  logic [7:0] rom_data,
  output logic       lcd_en,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic [7:0] lcd_db,
  output logic       lcd_rst
);

  localparam int IW = (INIT_CYC > 1) ? $clog2(INIT_CYC) : 1;
  localparam int DW = $clog2(DWELL + 1);
  localparam logic [IW-1:0] INIT_LAST = IW'(INIT_CYC - 1);
  localparam logic [DW-1:0] DWELL_MAX = DW'(DWELL);

  typedef enum logic [1:0] {S_INIT, S_FETCH, S_SETUP, S_STROBE} state_e;

  state_e        state_q, state_d;
  logic [IW-1:0] init_cnt_q, init_cnt_d;
  logic [4:0]    col_q, col_d;
  logic          line_q, line_d;
  logic [2:0]    gnt_q, gnt_d;
  logic [DW-1:0] dwell_q, dwell_d;
  logic [7:0]    lcd_db_q, lcd_db_d;

  logic          arb_now;
  logic [2:0]    hi_req;
  logic [2:0]    arb_gnt;
  logic [DW-1:0] arb_dwell;
  logic [1:0]    msg_id;
  logic          last_char;

  // Owner index + 1; a one-hot gnt maps directly onto the 2-bit message id.
  assign msg_id    = {gnt_q[2] | gnt_q[1], gnt_q[2] | gnt_q[0]};
  assign last_char = line_q & (&col_q);

  // Arbitration result, applied only at the frame boundary (or INIT exit).
  // One-hot codes compare numerically in priority order, so hi_req > gnt_q
  // means a strictly higher-priority requester is waiting.
  always_comb begin
    hi_req    = req[2] ? 3'b100 : req[1] ? 3'b010 : req[0] ? 3'b001 : 3'b000;
    arb_gnt   = gnt_q;
    arb_dwell = dwell_q;
    if (|(gnt_q & req)) begin
      if (dwell_q < DWELL_MAX) begin
        arb_dwell = dwell_q + DW'(1);
      end else if (hi_req > gnt_q) begin
        arb_gnt   = hi_req;
        arb_dwell = '0;
      end
    end else begin
      arb_gnt   = hi_req;
      arb_dwell = '0;
    end
  end

  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    col_d      = col_q;
    line_d     = line_q;
    gnt_d      = gnt_q;
    dwell_d    = dwell_q;
    lcd_db_d   = lcd_db_q;
    arb_now    = 1'b0;
    case (state_q)
      S_INIT: begin
        if (init_cnt_q == INIT_LAST) begin
          state_d = S_FETCH;
          arb_now = 1'b1;
        end else begin
          init_cnt_d = init_cnt_q + IW'(1);
        end
      end
      S_FETCH: state_d = S_SETUP;
      S_SETUP: begin
        // ROM data for the address shown in FETCH is valid now.
        lcd_db_d = rom_data;
        state_d  = S_STROBE;
      end
      S_STROBE: begin
        state_d = S_FETCH;
        col_d   = col_q + 5'd1;
        if (&col_q) line_d = ~line_q;
        arb_now = last_char;
      end
      default: state_d = S_INIT;
    endcase
    if (arb_now) begin
      gnt_d   = arb_gnt;
      dwell_d = arb_dwell;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_INIT;
      init_cnt_q <= '0;
      col_q      <= '0;
      line_q     <= 1'b0;
      gnt_q      <= '0;
      dwell_q    <= '0;
      lcd_db_q   <= '0;
    end else begin
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
      col_q      <= col_d;
      line_q     <= line_d;
      gnt_q      <= gnt_d;
      dwell_q    <= dwell_d;
      lcd_db_q   <= lcd_db_d;
    end
  end

  assign gnt        = gnt_q;
  assign frame_done = (state_q == S_STROBE) & last_char;
  assign rom_addr   = {msg_id, line_q, col_q};
  assign lcd_en     = (state_q == S_STROBE);
  assign lcd_rs     = 1'b1;
  assign lcd_rw     = 1'b0;
  assign lcd_db     = lcd_db_q;
  assign lcd_rst    = (state_q == S_INIT);

endmodule

// File: tb/tb_lcd_msg_sched.sv
module tb_lcd_msg_sched;

  localparam int DWELL    = 4;
  localparam int INIT_CYC = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] req;
  logic [2:0] gnt;
  logic       frame_done;
  logic [7:0] rom_addr;
  logic [7:0] rom_data = 8'h00;
  logic       lcd_en, lcd_rs, lcd_rw, lcd_rst;
  logic [7:0] lcd_db;

  lcd_msg_sched #(.DWELL(DWELL), .INIT_CYC(INIT_CYC)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .gnt(gnt), .frame_done(frame_done),
    .rom_addr(rom_addr), .rom_data(rom_data), .lcd_en(lcd_en), .lcd_rs(lcd_rs),
    .lcd_rw(lcd_rw), .lcd_db(lcd_db), .lcd_rst(lcd_rst)
  );

  always #5 clk = ~clk;

  // Synchronous message ROM: one address gets a known code, the rest a simple mix.
  function automatic logic [7:0] rom_f(input logic [7:0] a);
    return (a == 8'h43) ? 8'h24 : (a ^ 8'h5A);
  endfunction

  always @(posedge clk) rom_data <= rom_f(rom_addr);

  int n_total = 0;
  int n_bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got=%0h exp=%0h", tag, $time, got, exp);
    end
  endtask

  // Reference model: cycle index since reset, owner index (-1 = none), dwell count.
  typedef struct {
    logic [7:0] addr;
    logic [7:0] data;
    logic       fd;
  } exp_t;

  exp_t       sbq[$];
  int         m_cyc     = 0;
  bit         m_inrst   = 1'b0;
  bit         m_started = 1'b0;
  int         m_own     = -1;
  int         m_dwell   = 0;
  logic [7:0] m_last_db = 8'h00;

  task automatic model_arbitrate();
    int top;
    top = -1;
    for (int i = 0; i < 3; i++) if (req[i]) top = i;
    if (m_own >= 0 && req[m_own]) begin
      if (m_dwell < DWELL) m_dwell++;
      else if (top > m_own) begin
        m_own   = top;
        m_dwell = 0;
      end
    end else begin
      m_own   = top;
      m_dwell = 0;
    end
  endtask

  function automatic logic [2:0] model_gnt();
    return (m_own < 0) ? 3'b000 : (3'b001 << m_own);
  endfunction

  always @(posedge clk) begin
    m_started = 1'b1;
    if (!rst_n) begin
      m_inrst   = 1'b1;
      m_cyc     = 0;
      m_own     = -1;
      m_dwell   = 0;
      m_last_db = 8'h00;
      sbq.delete();
    end else begin
      m_inrst = 1'b0;
      if (m_cyc == INIT_CYC - 1) model_arbitrate();
      if (m_cyc >= INIT_CYC && (m_cyc - INIT_CYC) % 3 == 2 &&
          ((m_cyc - INIT_CYC) / 3) % 64 == 63)
        model_arbitrate();
      m_cyc++;
      if (m_cyc >= INIT_CYC && (m_cyc - INIT_CYC) % 3 == 0) begin
        int   k;
        exp_t e;
        k      = ((m_cyc - INIT_CYC) / 3) % 64;
        e.addr = {2'(m_own + 1), k[5], k[4:0]};
        e.data = rom_f(e.addr);
        e.fd   = (k == 63);
        sbq.push_back(e);
      end
    end
  end

  always @(negedge clk) begin
    if (m_started) begin
      if (m_inrst) begin
        chk("rst_lcd_en", lcd_en, 1'b0);
        chk("rst_lcd_db", lcd_db, 8'h00);
        chk("rst_lcd_rst", lcd_rst, 1'b1);
        chk("rst_gnt", gnt, 3'b000);
        chk("rst_frame_done", frame_done, 1'b0);
        chk("rst_rom_addr", rom_addr, 8'h00);
      end else begin
        chk("lcd_rst", lcd_rst, m_cyc < INIT_CYC);
        chk("lcd_en", lcd_en, m_cyc >= INIT_CYC && (m_cyc - INIT_CYC) % 3 == 2);
        chk("gnt", gnt, model_gnt());
        chk("lcd_rs", lcd_rs, 1'b1);
        chk("lcd_rw", lcd_rw, 1'b0);
        if (m_cyc >= INIT_CYC && (m_cyc - INIT_CYC) % 3 == 0) begin
          if (sbq.size() == 0) chk("sb_addr_empty", 1'b0, 1'b1);
          else chk("rom_addr", rom_addr, sbq[0].addr);
        end
        if (lcd_en) begin
          if (sbq.size() == 0) chk("sb_strobe_empty", 1'b0, 1'b1);
          else begin
            exp_t e;
            e = sbq.pop_front();
            chk("lcd_db_strobe", lcd_db, e.data);
            chk("frame_done", frame_done, e.fd);
            m_last_db = e.data;
          end
        end else begin
          chk("frame_done_idle", frame_done, 1'b0);
          chk("lcd_db_hold", lcd_db, m_last_db);
        end
      end
    end
  end

  localparam int FRAME = 192;

  initial begin
    rst_n = 1'b0;
    req   = 3'b000;
    // Blank message, no requests.
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (INIT_CYC + FRAME + 20) @(negedge clk);

    // Title from reset, game-over raised after the first frame: dwell then preempt.
    rst_n = 1'b0;
    req   = 3'b001;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (INIT_CYC + FRAME + 30) @(negedge clk);
    req = 3'b101;
    repeat (FRAME * 5) @(negedge clk);

    // Score owner drops mid-frame while title is waiting.
    rst_n = 1'b0;
    req   = 3'b010;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (INIT_CYC + FRAME + 10) @(negedge clk);
    req = 3'b011;
    repeat (90) @(negedge clk);
    req = 3'b001;
    repeat (FRAME * 2) @(negedge clk);

    // Short game-over pulse inside a frame is never granted.
    repeat (50) @(negedge clk);
    req = 3'b101;
    repeat (10) @(negedge clk);
    req = 3'b001;
    repeat (FRAME + 20) @(negedge clk);

    // One-cycle reset at col 17 of the first frame.
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (INIT_CYC + 17 * 3 + 1) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (FRAME + 20) @(negedge clk);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
